// File: rtl/timer_6502_if.sv
// Bus interface between the 6502 core and the page-3 interval timer.
interface timer_6502_if;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (
    output cs, we, rs, din,
    input  dout, irq
  );

  modport slave (
    input  cs, we, rs, din,
    output dout, irq
  );
endinterface

// File: rtl/timer_6502.sv
// 16-bit interval timer for the hx1k 6502 system, mapped at CPU page 3.
// Prescaled down-counter with one-shot or auto-reload, atomic 16-bit read
// via a high-byte snapshot, and a registered level IRQ.
module timer_6502 #(
  parameter int unsigned PRESCALE = 16
) (
  input logic         clk,
  input logic         rst,
  timer_6502_if.slave bus
);

  localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  reload_lo_q, reload_lo_d;
  logic [7:0]  hi_latch_q, hi_latch_d;
  logic [2:0]  ctrl_q, ctrl_d;  // {irq_en, auto_reload, enable}
  logic        expired_q, expired_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;

  logic       rd_stb, wr_stb;
  logic       commit, ctrl_wr, w1c, tick, expire, start;
  logic [7:0] rd_data;

  assign rd_stb  = bus.cs & ~bus.we;
  assign wr_stb  = bus.cs & bus.we;
  assign commit  = wr_stb && (bus.rs == 2'd1);
  assign ctrl_wr = wr_stb && (bus.rs == 2'd2);
  assign w1c     = wr_stb && (bus.rs == 2'd3) && bus.din[0];
  assign tick    = ctrl_q[0] && (presc_q == PresLast);
  // A reload commit pre-empts the tick entirely, including expiry.
  assign expire  = tick && !commit && (count_q == 16'd0);
  assign start   = ctrl_wr && bus.din[0] && !ctrl_q[0];

  // Read mux: value selected at the read edge, before any state update.
  always_comb begin
    rd_data = 8'h00;
    case (bus.rs)
      2'd0:    rd_data = count_q[7:0];
      2'd1:    rd_data = hi_latch_q;
      2'd2:    rd_data = {5'b0, ctrl_q};
      default: rd_data = {7'b0, expired_q};
    endcase
  end

  // Next-state for counter, registers, flag, prescaler and read path.
  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    reload_lo_d = reload_lo_q;
    hi_latch_d  = hi_latch_q;
    ctrl_d      = ctrl_q;
    expired_d   = expired_q;
    presc_d     = presc_q;
    dout_d      = dout_q;
    irq_d       = expired_q & ctrl_q[2];

    if (wr_stb && (bus.rs == 2'd0)) begin
      reload_lo_d = bus.din;
    end

    if (commit) begin
      reload_d = {bus.din, reload_lo_q};
      count_d  = {bus.din, reload_lo_q};
    end else if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q[1]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[0] = 1'b0;  // one-shot stop
      end
    end

    // An explicit ctrl write overrides the one-shot auto-clear.
    if (ctrl_wr) begin
      ctrl_d = bus.din[2:0];
    end

    // Set beats clear when expiry and W1C coincide.
    if (w1c) begin
      expired_d = 1'b0;
    end
    if (expire) begin
      expired_d = 1'b1;
    end

    if (!ctrl_d[0] || commit || start || tick) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    if (rd_stb) begin
      dout_d = rd_data;
      if (bus.rs == 2'd0) begin
        hi_latch_d = count_q[15:8];
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 16'd0;
      reload_q    <= 16'd0;
      reload_lo_q <= 8'd0;
      hi_latch_q  <= 8'd0;
      ctrl_q      <= 3'd0;
      expired_q   <= 1'b0;
      presc_q     <= 16'd0;
      dout_q      <= 8'd0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      reload_lo_q <= reload_lo_d;
      hi_latch_q  <= hi_latch_d;
      ctrl_q      <= ctrl_d;
      expired_q   <= expired_d;
      presc_q     <= presc_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_timer_6502.sv
// Directed bench for timer_6502: one instance with PRESCALE=4, one with 1.
module tb_timer_6502;

  logic       clk;
  logic       rst;
  logic       cs, we, sel;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  int n_tests;
  int n_fail;

  timer_6502_if if4 ();
  timer_6502_if if1 ();

  // sel chooses which instance sees the chip select and is observed.
  assign if4.cs  = cs & ~sel;
  assign if4.we  = we;
  assign if4.rs  = rs;
  assign if4.din = din;
  assign if1.cs  = cs & sel;
  assign if1.we  = we;
  assign if1.rs  = rs;
  assign if1.din = din;
  assign dout    = sel ? if1.dout : if4.dout;
  assign irq     = sel ? if1.irq : if4.irq;

  timer_6502 #(.PRESCALE(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  timer_6502 #(.PRESCALE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a negedge; the access lands on the posedge between.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = r; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] r, input logic [7:0] exp);
    cs = 1'b1; we = 1'b0; rs = r;
    @(negedge clk);
    cs = 1'b0;
    check(tag, dout, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00; sel = 1'b0;
    rst = 1'b1;

    // Reset state
    cyc(2);
    rst = 1'b0;
    check("rst_dout4", if4.dout, 8'h00);
    check("rst_irq4", {7'b0, if4.irq}, 8'h00);
    check("rst_dout1", if1.dout, 8'h00);
    check("rst_irq1", {7'b0, if1.irq}, 8'h00);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rst_rd%0d", i), 2'(i), 8'h00);

    // Write with cs low must be ignored
    cs = 1'b0; we = 1'b1; rs = 2'd2; din = 8'h07;
    cyc(1);
    we = 1'b0;
    rd_chk("cs0_ignored", 2'd2, 8'h00);

    // Auto-reload, PRESCALE=1, reload=2: expiry every 3 clks
    sel = 1'b1;
    wr(2'd0, 8'h02);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h03);                 // edge W
    cs = 1'b1; we = 1'b0; rs = 2'd3; // continuous status read
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check("ar_exp_w2", dout, 8'h00);
      if (k == 4) check("ar_exp_w3", dout, 8'h01);
    end
    cs = 1'b0;
    wr(2'd3, 8'h01);                 // W+5 clear
    rd_chk("ar_w1c", 2'd3, 8'h00);   // W+6
    wr(2'd3, 8'h01);                 // W+7 clear again
    rd_chk("ar_w1c2", 2'd3, 8'h00);  // W+8
    wr(2'd3, 8'h01);                 // W+9 expiry: set wins
    rd_chk("ar_set_wins", 2'd3, 8'h01);
    check("ar_irq_off", {7'b0, irq}, 8'h00);

    // Atomic 16-bit read across rollover, reload=0x0100
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h03);                 // W: count 0x0100
    rd_chk("atom_lo", 2'd0, 8'h00);  // snapshot hi=0x01, live goes to 0x00FF
    rd_chk("atom_hi", 2'd1, 8'h01);
    rd_chk("atom_lo2", 2'd0, 8'hFE);
    rd_chk("atom_hi2", 2'd1, 8'h00);

    // Reload commit on a tick edge, PRESCALE=4
    sel = 1'b0;
    wr(2'd0, 8'h20);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h03);                 // W, ticks at W+4, W+8, ...
    cyc(6);
    wr(2'd0, 8'h10);                 // W+7
    wr(2'd1, 8'h00);                 // W+8 tick edge: commit wins
    rd_chk("rc_commit", 2'd0, 8'h10);
    cyc(3);
    rd_chk("rc_next_tick", 2'd0, 8'h0F);  // W+12 tick seen at W+13
    rd_chk("rc_no_expiry", 2'd3, 8'h00);
    // Off-tick commit restarts the prescaler phase
    wr(2'd0, 8'h08);                 // W+15
    cyc(1);                          // W+16 tick
    wr(2'd1, 8'h00);                 // W+17 commit, prescaler to 0
    cyc(3);
    rd_chk("rc_restart_hold", 2'd0, 8'h08);  // no tick before W+21
    rd_chk("rc_restart_tick", 2'd0, 8'h07);

    // One-shot, PRESCALE=4, reload=3, irq_en
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h03);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h05);                 // edge W
    cs = 1'b1; we = 1'b0; rs = 2'd3;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check("os_exp_early", dout, 8'h00);
        check("os_irq_early", {7'b0, irq}, 8'h00);
      end
      if (k == 17) begin
        check("os_exp_w16", dout, 8'h01);
        check("os_irq_w17", {7'b0, irq}, 8'h01);
      end
    end
    cs = 1'b0;
    rd_chk("os_ctrl", 2'd2, 8'h04);
    cyc(8);
    rd_chk("os_count_lo", 2'd0, 8'h00);
    rd_chk("os_count_hi", 2'd1, 8'h00);

    // Mid-operation reset with irq high and count=5
    wr(2'd0, 8'h05);
    wr(2'd1, 8'h00);
    rd_chk("mr_count", 2'd0, 8'h05);
    check("mr_irq_pre", {7'b0, irq}, 8'h01);
    rst = 1'b1;
    cyc(1);
    check("mr_irq_drop", {7'b0, irq}, 8'h00);
    check("mr_dout", dout, 8'h00);
    rst = 1'b0;
    cyc(8);
    rd_chk("mr_count0", 2'd0, 8'h00);
    rd_chk("mr_ctrl0", 2'd2, 8'h00);
    rd_chk("mr_status0", 2'd3, 8'h00);
    check("mr_irq_idle", {7'b0, irq}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
